// File: rtl/uart_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_axi_bridge_pkg
// Description : Shared types and constants for the UART-to-AXI debug bridge:
//               FSM state encoding, AXI response codes, command header
//               field positions and a response-severity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_axi_bridge_pkg;

  typedef enum logic [3:0] {
    S_HDR   = 4'd0,
    S_ADDR  = 4'd1,
    S_WDATA = 4'd2,
    S_AR    = 4'd3,
    S_R     = 4'd4,
    S_TX    = 4'd5,
    S_AWW   = 4'd6,
    S_B     = 4'd7,
    S_STAT  = 4'd8
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int HDR_WR_BIT  = 7;
  localparam int HDR_CNT_MSB = 6;
  localparam int HDR_CNT_LSB = 0;

  // Responses are ordered by severity numerically, so the worst is the max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_axi_bridge_if
// Description : Bundles the UART byte streams and the five AXI channels seen
//               by the bridge.
//               master : bridge side (consumes rx bytes, produces tx bytes,
//                        drives AR/AW/W, consumes R/B)
//               slave  : environment side (UART PHY and AXI slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_axi_bridge_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) ();

  logic [7:0]        uart_rx;
  logic              uart_rx_valid;
  logic              uart_rx_ready;
  logic [7:0]        uart_tx;
  logic              uart_tx_valid;
  logic              uart_tx_ready;

  logic [ADDR_W-1:0] axi_ar_addr;
  logic              axi_ar_valid;
  logic              axi_ar_ready;
  logic [DATA_W-1:0] axi_r_data;
  logic [1:0]        axi_r_resp;
  logic              axi_r_valid;
  logic              axi_r_ready;
  logic [ADDR_W-1:0] axi_aw_addr;
  logic              axi_aw_valid;
  logic              axi_aw_ready;
  logic [DATA_W-1:0] axi_w_data;
  logic              axi_w_valid;
  logic              axi_w_ready;
  logic [1:0]        axi_b_resp;
  logic              axi_b_valid;
  logic              axi_b_ready;

  modport master (
    input  uart_rx, uart_rx_valid, output uart_rx_ready,
    output uart_tx, uart_tx_valid, input  uart_tx_ready,
    output axi_ar_addr, axi_ar_valid, input axi_ar_ready,
    input  axi_r_data, axi_r_resp, axi_r_valid, output axi_r_ready,
    output axi_aw_addr, axi_aw_valid, input axi_aw_ready,
    output axi_w_data, axi_w_valid, input axi_w_ready,
    input  axi_b_resp, axi_b_valid, output axi_b_ready
  );

  modport slave (
    output uart_rx, uart_rx_valid, input  uart_rx_ready,
    input  uart_tx, uart_tx_valid, output uart_tx_ready,
    input  axi_ar_addr, axi_ar_valid, output axi_ar_ready,
    output axi_r_data, axi_r_resp, axi_r_valid, input axi_r_ready,
    input  axi_aw_addr, axi_aw_valid, output axi_aw_ready,
    input  axi_w_data, axi_w_valid, output axi_w_ready,
    output axi_b_resp, axi_b_valid, input axi_b_ready
  );

endinterface
`default_nettype wire

// File: rtl/uart_axi_bridge_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Loads a word plus a byte count and emits the bytes LSB first
//               on a valid/ready stream. o_done pulses on the handshake of
//               the final byte.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_load          - load i_data / i_nbytes (idle only)
//               i_data          - word to send
//               i_nbytes        - bytes to send (0 sends nothing)
//               o_tx/o_tx_valid/i_tx_ready - transmit byte stream
//               o_done          - last byte accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
  parameter int DATA_W = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_load,
  input  wire logic [DATA_W-1:0] i_data,
  input  wire logic [2:0]        i_nbytes,
  output logic      [7:0]        o_tx,
  output logic                   o_tx_valid,
  input  wire logic              i_tx_ready,
  output logic                   o_done
);

  logic [DATA_W-1:0] r_shift;
  logic [2:0]        r_left;
  logic              r_valid;
  logic              w_hs;

  assign w_hs       = r_valid && i_tx_ready;
  assign o_done     = w_hs && (r_left == 3'd1);
  assign o_tx       = r_shift[7:0];
  assign o_tx_valid = r_valid;

  // The next byte is presented in the same edge the current one is taken,
  // so a multi-byte word streams without bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_left  <= 3'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_left  <= i_nbytes;
      r_valid <= (i_nbytes != 3'd0);
    end else if (w_hs) begin
      r_shift <= r_shift >> 8;
      r_left  <= r_left - 3'd1;
      if (r_left == 3'd1) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_axi_bridge
// Description : UART-to-AXI debug bridge. Parses framed read/write commands
//               from the rx byte stream, issues one single-beat AXI
//               transaction per burst beat, and returns read data plus a
//               status byte (worst response of the burst) on the tx stream.
//               Partial commands are dropped after TIMEOUT_CYC idle cycles.
// Ports       : clk, rst_n - clock, async active-low reset
//               bus         - uart_axi_bridge_if.master (UART streams, AXI)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_axi_bridge #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  uart_axi_bridge_if.master bus
);

  import uart_axi_bridge_pkg::*;

  localparam int AB = (ADDR_W + 7) / 8;
  localparam int DB = DATA_W / 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state;
  logic              r_rx_ready;
  logic              r_ar_valid;
  logic              r_r_ready;
  logic              r_aw_valid;
  logic              r_w_valid;
  logic              r_b_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic [6:0]        r_beats;     // beats remaining after the current one
  logic [2:0]        r_bcnt;      // byte index within address / data word
  logic [1:0]        r_status;
  logic [TW-1:0]     r_tmo;

  logic              w_rx_hs;
  logic              w_ar_hs;
  logic              w_r_hs;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_aw_done;
  logic              w_w_done;
  logic              w_tmo_hit;
  logic [1:0]        w_stat_r;
  logic [1:0]        w_stat_b;
  logic              w_ser_load;
  logic [DATA_W-1:0] w_ser_data;
  logic [2:0]        w_ser_nbytes;
  logic              w_ser_done;

  assign w_rx_hs   = bus.uart_rx_valid && r_rx_ready;
  assign w_ar_hs   = r_ar_valid && bus.axi_ar_ready;
  assign w_r_hs    = bus.axi_r_valid && r_r_ready;
  assign w_aw_hs   = r_aw_valid && bus.axi_aw_ready;
  assign w_w_hs    = r_w_valid && bus.axi_w_ready;
  assign w_b_hs    = bus.axi_b_valid && r_b_ready;
  // A channel counts as done if it already completed or completes now.
  assign w_aw_done = !r_aw_valid || bus.axi_aw_ready;
  assign w_w_done  = !r_w_valid || bus.axi_w_ready;
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_stat_r  = resp_max(r_status, bus.axi_r_resp);
  assign w_stat_b  = resp_max(r_status, bus.axi_b_resp);

  assign bus.uart_rx_ready = r_rx_ready;
  assign bus.axi_ar_addr   = r_addr;
  assign bus.axi_ar_valid  = r_ar_valid;
  assign bus.axi_r_ready   = r_r_ready;
  assign bus.axi_aw_addr   = r_addr;
  assign bus.axi_aw_valid  = r_aw_valid;
  assign bus.axi_w_data    = r_wdata;
  assign bus.axi_w_valid   = r_w_valid;
  assign bus.axi_b_ready   = r_b_ready;

  // Serializer load is combinational so tx_valid appears on the cycle right
  // after the R / final-B handshake or the last data byte.
  always_comb begin
    w_ser_load   = 1'b0;
    w_ser_data   = '0;
    w_ser_nbytes = 3'd0;
    case (r_state)
      S_R: begin
        if (w_r_hs) begin
          w_ser_load   = 1'b1;
          w_ser_data   = bus.axi_r_data;
          w_ser_nbytes = 3'(DB);
        end
      end
      S_TX: begin
        if (w_ser_done && (r_beats == 7'd0)) begin
          w_ser_load   = 1'b1;
          w_ser_data   = DATA_W'(r_status);
          w_ser_nbytes = 3'd1;
        end
      end
      S_B: begin
        if (w_b_hs && (r_beats == 7'd0)) begin
          w_ser_load   = 1'b1;
          w_ser_data   = DATA_W'(w_stat_b);
          w_ser_nbytes = 3'd1;
        end
      end
      default: ;
    endcase
  end

  uart_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ser_load),
    .i_data     (w_ser_data),
    .i_nbytes   (w_ser_nbytes),
    .o_tx       (bus.uart_tx),
    .o_tx_valid (bus.uart_tx_valid),
    .i_tx_ready (bus.uart_tx_ready),
    .o_done     (w_ser_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HDR;
      r_rx_ready <= 1'b1;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_write    <= 1'b0;
      r_beats    <= 7'd0;
      r_bcnt     <= 3'd0;
      r_status   <= RESP_OKAY;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_rx_hs) begin
            r_write  <= bus.uart_rx[HDR_WR_BIT];
            r_beats  <= bus.uart_rx[HDR_CNT_MSB:HDR_CNT_LSB];
            r_status <= RESP_OKAY;
            r_bcnt   <= 3'd0;
            r_tmo    <= '0;
            r_state  <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (w_rx_hs) begin
            // MSB-first shift; bits above ADDR_W fall off the top.
            r_addr <= (r_addr << 8) | ADDR_W'(bus.uart_rx);
            r_tmo  <= '0;
            if (r_bcnt == 3'(AB - 1)) begin
              r_bcnt <= 3'd0;
              if (r_write) begin
                r_state <= S_WDATA;
              end else begin
                r_rx_ready <= 1'b0;
                r_ar_valid <= 1'b1;
                r_state    <= S_AR;
              end
            end else begin
              r_bcnt <= r_bcnt + 3'd1;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_HDR;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_WDATA: begin
          if (w_rx_hs) begin
            // LSB-first: each new byte enters at the top and moves down.
            r_wdata <= (r_wdata >> 8) | (DATA_W'(bus.uart_rx) << (DATA_W - 8));
            r_tmo   <= '0;
            if (r_bcnt == 3'(DB - 1)) begin
              r_bcnt     <= 3'd0;
              r_rx_ready <= 1'b0;
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
              r_state    <= S_AWW;
            end else begin
              r_bcnt <= r_bcnt + 3'd1;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_HDR;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_AR: begin
          if (w_ar_hs) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_R;
          end
        end

        S_R: begin
          if (w_r_hs) begin
            r_r_ready <= 1'b0;
            r_status  <= w_stat_r;
            r_state   <= S_TX;
          end
        end

        S_TX: begin
          if (w_ser_done) begin
            if (r_beats != 7'd0) begin
              r_beats    <= r_beats - 7'd1;
              r_addr     <= r_addr + ADDR_W'(1);
              r_ar_valid <= 1'b1;
              r_state    <= S_AR;
            end else begin
              r_state <= S_STAT;
            end
          end
        end

        S_AWW: begin
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
          end
          if (w_w_hs) begin
            r_w_valid <= 1'b0;
          end
          if (w_aw_done && w_w_done) begin
            r_b_ready <= 1'b1;
            r_state   <= S_B;
          end
        end

        S_B: begin
          if (w_b_hs) begin
            r_b_ready <= 1'b0;
            r_status  <= w_stat_b;
            if (r_beats != 7'd0) begin
              r_beats    <= r_beats - 7'd1;
              r_addr     <= r_addr + ADDR_W'(1);
              r_rx_ready <= 1'b1;
              r_bcnt     <= 3'd0;
              r_tmo      <= '0;
              r_state    <= S_WDATA;
            end else begin
              r_state <= S_STAT;
            end
          end
        end

        S_STAT: begin
          if (w_ser_done) begin
            r_rx_ready <= 1'b1;
            r_state    <= S_HDR;
          end
        end

        default: begin
          r_state    <= S_HDR;
          r_rx_ready <= 1'b1;
          r_ar_valid <= 1'b0;
          r_r_ready  <= 1'b0;
          r_aw_valid <= 1'b0;
          r_w_valid  <= 1'b0;
          r_b_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_axi_bridge.md
# uart_axi_bridge

UART-to-AXI debug bridge: parses framed read/write commands from the byte-stream UART receiver, issues single-beat AXI transactions on the on-chip bus, and returns read data plus a status byte on the UART transmitter. It replaces the fixed read-only 18/16-bit debug port with a parametrised bridge that adds writes, bursts, response reporting and a command timeout.

## Interface
- ADDR_W, 18: AXI word-address width, 1..32.
- DATA_W, 16: AXI data width, multiple of 8, 8..32.
- TIMEOUT_CYC, 1000000: idle cycles allowed between bytes of a partial command; must be at least 1.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- uart_rx / uart_rx_valid / uart_rx_ready  in/in/out  8/1/1  received-byte stream.
- uart_tx / uart_tx_valid / uart_tx_ready  out/out/in  8/1/1  transmit-byte stream.
- axi_ar_addr / axi_ar_valid / axi_ar_ready  out/out/in  ADDR_W/1/1.
- axi_r_data / axi_r_resp / axi_r_valid / axi_r_ready  in/in/in/out  DATA_W/2/1/1.
- axi_aw_addr / axi_aw_valid / axi_aw_ready  out/out/in  ADDR_W/1/1.
- axi_w_data / axi_w_valid / axi_w_ready  out/out/in  DATA_W/1/1.
- axi_b_resp / axi_b_valid / axi_b_ready  in/in/out  2/1/1.

## Operation
- Derived constants: AB = ceil(ADDR_W/8) address bytes; DB = DATA_W/8 data bytes.
- Every stream and channel handshake completes on a cycle where valid and ready are both high. Each valid, with its data, stays asserted and stable until it is accepted.
- Frame layout:
  - Header byte: bit7 = write (1) or read (0); bits[6:0] = N. The burst is N+1 beats (1..128).
  - Then AB address bytes, MSB first. Address bits above ADDR_W are ignored.
  - For writes, then (N+1)×DB data bytes, each word LSB first.
- Each beat is its own AXI transaction. The address increments by 1 per beat and wraps from 2^ADDR_W−1 to 0.
- Read response: DB bytes per beat, LSB first, then one status byte.
- Write response: one status byte only.
- Status byte = {6'b0, max resp over all beats}. OKAY returns 0x00. Data is still returned for error beats.
- States:
  - HDR: rx_ready=1. Accept a byte → ADDR.
  - ADDR: rx_ready=1. On the AB-th byte → AR (read) or WDATA (write).
  - WDATA: rx_ready=1. On the DB-th byte → AWW.
  - AR: ar_valid=1. Handshake → R.
  - R: r_ready=1. Handshake captures data and resp → TX.
  - TX: send DB bytes. If beats remain → AR with address+1, else → STAT.
  - AWW: aw_valid and w_valid asserted together; each drops independently on its own handshake. When both are done → B.
  - B: b_ready=1. Handshake → WDATA with address+1 if beats remain, else → STAT.
  - STAT: send the status byte → HDR.
- uart_rx_ready is 0 in every state other than HDR, ADDR and WDATA.
- Timeout:
  - The counter runs only in ADDR and WDATA and reloads on every accepted byte.
  - Reaching TIMEOUT_CYC drops the frame and returns to HDR. No AXI activity results and no response is sent.
  - A timeout in WDATA after earlier beats were written leaves those writes done and sends no status byte.

## Timing
- Reset values:
  - uart_rx_ready = 1 (state HDR).
  - All valid and ready outputs = 0.
  - All address and data outputs = 0.
  - Status accumulator = 0.
- Reset asserted mid-operation forces these values immediately. The in-flight AXI transaction is abandoned, so the slave must share rst_n.
- axi_ar_valid / axi_aw_valid / axi_w_valid rise on the cycle after the last address or data byte is accepted.
- axi_ar_valid rises 1 cycle after the previous beat's last TX byte is accepted.
- uart_tx_valid rises on the cycle after the R handshake, or after the final B handshake for STAT.
- Consecutive TX bytes go back-to-back: uart_tx updates in the same cycle the previous byte is accepted.
- If aw and w handshakes happen in the same cycle, B is entered on the next cycle.
- b_valid is ignored (b_ready=0) until both aw and w handshakes are complete.

## Structure
- Package uart_axi_bridge_pkg holds:
  - state enum;
  - AXI resp constants OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - header field positions: write bit 7, count [6:0].
- One sub-module, uart_tx_serializer:
  - loads a DATA_W word plus a byte count;
  - emits bytes LSB first on the tx handshake;
  - signals done.

## Test plan
- Single read (ADDR_W=18, DATA_W=16): rx 0x00,0x01,0x23,0x45, slave returns 0xBEEF/OKAY → ar_addr=0x12345; tx 0xEF,0xBE,0x00.
- Burst read with wrap: header 0x02, address 0x3FFFF → ar_addr 0x3FFFF, 0x00000, 0x00001; 7 tx bytes, last one 0x00.
- Write: rx 0x80,0x00,0x00,0x10,0x34,0x12 → aw_addr=0x10, w_data=0x1234; b OKAY → tx 0x00 only.
- Error: 2-beat read with SLVERR on beat 2 → all 4 data bytes sent, then status 0x02.
- Timeout: rx 0x00,0x01, then idle TIMEOUT_CYC cycles → no AXI valid; a following full read command completes normally.
- Backpressure and reset:
  - aw_ready arrives 5 cycles before w_ready → aw_valid drops early, w_valid holds, B is entered after w.
  - rst_n asserted during R → all valids and r_ready go to 0 and rx_ready goes to 1 without waiting for a clock edge.
